// File: rtl/lcm_sent_ctrl.sv
// Transmit scheduler: turns the latched send configuration into a paced stream of
// packet requests (start delay, inter-packet gap, count or time limit) over req/ack.
module lcm_sent_ctrl #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sent_start,
  input  logic             sent_model,
  input  logic [CNT_W-1:0] sent_start_time,
  input  logic [CNT_W-1:0] sent_rate,
  input  logic [CNT_W-1:0] sent_time,
  input  logic [CNT_W-1:0] sent_num,
  input  logic             pkt_ack,
  output logic             pkt_req,
  output logic             sent_busy,
  output logic             sent_done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   ONE_X = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             start_d;
  logic             model_q;
  logic [CNT_W-1:0] start_time_q;
  logic [CNT_W-1:0] rate_q;
  logic [CNT_W-1:0] time_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] delay_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] run_cnt;

  logic             zero_limit;
  logic             count_hit;
  logic             time_up;

  // run_cnt+1 is formed one bit wider so a saturated run_cnt still compares as expired
  assign zero_limit = model_q ? (time_q == '0) : (num_q == '0);
  assign count_hit  = !model_q && ((sent_cnt + ONE) == num_q);
  assign time_up    = model_q && (({1'b0, run_cnt} + ONE_X) >= {1'b0, time_q});

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (sent_start && !start_d)
          state_next = WAIT;
      end
      WAIT: begin
        if (!sent_start)
          state_next = IDLE;
        else if (zero_limit)
          state_next = DONE;
        else if (delay_cnt == start_time_q)
          state_next = SEND;
      end
      SEND: begin
        // an outstanding request is only released by its ack, even on abort
        if (pkt_ack) begin
          if (!sent_start)
            state_next = IDLE;
          else if (count_hit || time_up)
            state_next = DONE;
          else if (rate_q == '0)
            state_next = SEND;
          else
            state_next = GAP;
        end
      end
      GAP: begin
        if (!sent_start)
          state_next = IDLE;
        else if (time_up)
          state_next = DONE;
        else if (gap_cnt == ONE)
          state_next = SEND;
      end
      DONE: begin
        if (!sent_start)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_d      <= 1'b1;   // a level already high at reset release is not a start
      model_q      <= 1'b0;
      start_time_q <= '0;
      rate_q       <= '0;
      time_q       <= '0;
      num_q        <= '0;
      delay_cnt    <= '0;
      gap_cnt      <= '0;
      run_cnt      <= '0;
      sent_cnt     <= '0;
      pkt_req      <= 1'b0;
      sent_busy    <= 1'b0;
      sent_done    <= 1'b0;
    end else begin
      state     <= state_next;
      start_d   <= sent_start;
      pkt_req   <= (state_next == SEND);
      sent_busy <= (state_next == WAIT) || (state_next == SEND) || (state_next == GAP);
      sent_done <= (state_next == DONE);

      unique case (state)
        IDLE: begin
          if (state_next == WAIT) begin
            model_q      <= sent_model;
            start_time_q <= sent_start_time;
            rate_q       <= sent_rate;
            time_q       <= sent_time;
            num_q        <= sent_num;
            sent_cnt     <= '0;
            delay_cnt    <= '0;
            run_cnt      <= '0;
          end
        end
        WAIT: begin
          if (state_next == WAIT)
            delay_cnt <= delay_cnt + ONE;
        end
        SEND: begin
          if (pkt_ack)
            sent_cnt <= sent_cnt + ONE;
          if (state_next == GAP)
            gap_cnt <= rate_q;
        end
        GAP: begin
          gap_cnt <= gap_cnt - ONE;
        end
        default: ;
      endcase

      if (((state == SEND) || (state == GAP)) && (run_cnt != '1))
        run_cnt <= run_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_lcm_sent_ctrl.sv
// Directed bench for lcm_sent_ctrl: a timeline-based reference model checked every
// cycle, plus literal expectations on request timing and final counts per run.
module tb_lcm_sent_ctrl;

  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sent_start = 1'b0;
  logic             sent_model = 1'b0;
  logic [CNT_W-1:0] sent_start_time = '0;
  logic [CNT_W-1:0] sent_rate = '0;
  logic [CNT_W-1:0] sent_time = '0;
  logic [CNT_W-1:0] sent_num = '0;
  logic             pkt_ack = 1'b0;
  logic             pkt_req;
  logic             sent_busy;
  logic             sent_done;
  logic [CNT_W-1:0] sent_cnt;

  int checks = 0;
  int errors = 0;

  lcm_sent_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sent_start(sent_start), .sent_model(sent_model),
    .sent_start_time(sent_start_time), .sent_rate(sent_rate), .sent_time(sent_time),
    .sent_num(sent_num), .pkt_ack(pkt_ack), .pkt_req(pkt_req), .sent_busy(sent_busy),
    .sent_done(sent_done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline of absolute edge numbers (request rise edge,
  // deadline edge = first SEND edge + time) rather than a copy of the FSM counters.
  longint cyc = 0;
  bit     m_req = 0, m_busy = 0, m_done = 0, m_prev = 1, m_sent_any = 0;
  longint m_cnt = 0, m_rise = 0, m_deadline = 0;
  bit     c_model = 0;
  longint c_st = 0, c_rate = 0, c_time = 0, c_num = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req = 0; m_busy = 0; m_done = 0; m_prev = 1; m_sent_any = 0; m_cnt = 0;
    end else begin
      cyc++;
      if (!m_busy && !m_done) begin
        if (sent_start && !m_prev) begin
          c_model = sent_model;
          c_st = longint'(sent_start_time); c_rate = longint'(sent_rate);
          c_time = longint'(sent_time); c_num = longint'(sent_num);
          m_cnt = 0; m_busy = 1; m_sent_any = 0;
          m_rise = cyc + 1 + c_st;
        end
      end else if (m_done) begin
        if (!sent_start) m_done = 0;
      end else if (m_req) begin
        if (pkt_ack) begin
          m_cnt++;
          if (!sent_start) begin
            m_req = 0; m_busy = 0;
          end else if ((!c_model && m_cnt == c_num) || (c_model && cyc >= m_deadline)) begin
            m_req = 0; m_busy = 0; m_done = 1;
          end else if (c_rate != 0) begin
            m_req = 0; m_rise = cyc + c_rate;
          end
        end
      end else begin
        if (!sent_start) begin
          m_busy = 0;
        end else if (!m_sent_any && ((!c_model && c_num == 0) || (c_model && c_time == 0))) begin
          m_busy = 0; m_done = 1;
        end else if (m_sent_any && c_model && cyc >= m_deadline) begin
          m_busy = 0; m_done = 1;
        end else if (cyc == m_rise) begin
          m_req = 1;
          if (!m_sent_any) begin
            m_sent_any = 1; m_deadline = cyc + c_time;
          end
        end
      end
      m_prev = sent_start;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pkt_req", longint'(pkt_req), longint'(m_req));
      chk("sent_busy", longint'(sent_busy), longint'(m_busy));
      chk("sent_done", longint'(sent_done), longint'(m_done));
      chk("sent_cnt", longint'(sent_cnt), m_cnt);
    end
  end

  // Request monitor: rise edges and high-cycle count
  longint rises [0:255];
  int     n_rise = 0, hi_cycles = 0;
  bit     req_q = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_req && !req_q && n_rise < 256) begin
        rises[n_rise] = cyc;
        n_rise++;
      end
      if (pkt_req) hi_cycles++;
    end
    req_q = pkt_req;
  end

  // Ack responder: ack after ack_delay waiting cycles, or held high throughout
  bit ack_hold = 0;
  int ack_delay = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (ack_hold) begin
      pkt_ack = 1'b1;
    end else if (!pkt_req) begin
      wcnt = 0; pkt_ack = 1'b0;
    end else if (pkt_ack) begin
      wcnt = 1; pkt_ack = (ack_delay == 0);
    end else begin
      wcnt++; pkt_ack = (wcnt > ack_delay);
    end
  end

  longint start_edge = 0, done_edge = 0;
  int     rise0 = 0, hi0 = 0;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input bit md, input longint st, input longint rt,
                           input longint tm, input longint nm);
    sent_model = md;
    sent_start_time = st; sent_rate = rt; sent_time = tm; sent_num = nm;
    sent_start = 1'b1;
    start_edge = cyc + 1;
    rise0 = n_rise;
    hi0 = hi_cycles;
    step();
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!sent_done && i < budget) begin
      step();
      i++;
    end
    chk(name, longint'(sent_done), 1);
    done_edge = cyc;
  endtask

  task automatic stop_run(input string name);
    sent_start = 1'b0;
    step();
    step();
    chk(name, longint'({sent_busy, sent_done}), 0);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk("reset_pkt_req", longint'(pkt_req), 0);
    chk("reset_busy", longint'(sent_busy), 0);
    chk("reset_done", longint'(sent_done), 0);
    chk("reset_cnt", longint'(sent_cnt), 0);
    rst_n = 1'b1;
    step();
    step();

    // Count mode: start_time=3, rate=2, num=4, immediate ack
    ack_delay = 0;
    start_run(0, 3, 2, 20, 4);
    wait_done("count_done", 100);
    chk("count_cnt", longint'(sent_cnt), 4);
    chk("count_nreq", longint'(n_rise - rise0), 4);
    chk("count_hi", longint'(hi_cycles - hi0), 4);
    chk("count_first_req", rises[rise0], start_edge + 4);
    for (int i = 0; i < 3; i++)
      chk("count_spacing", rises[rise0 + i + 1] - rises[rise0 + i], 3);
    $display("run count_mode: sent_cnt=%0d first_req_edge=%0d", sent_cnt, rises[rise0] - start_edge);
    stop_run("count_stop");
    chk("count_cnt_hold", longint'(sent_cnt), 4);

    // Back-to-back: rate=0, num=5, ack held high (also high outside SEND)
    ack_hold = 1;
    start_run(0, 0, 0, 0, 5);
    wait_done("b2b_done", 50);
    chk("b2b_cnt", longint'(sent_cnt), 5);
    chk("b2b_nreq", longint'(n_rise - rise0), 1);
    chk("b2b_hi", longint'(hi_cycles - hi0), 5);
    $display("run back_to_back: sent_cnt=%0d req_high_cycles=%0d", sent_cnt, hi_cycles - hi0);
    stop_run("b2b_stop");
    ack_hold = 0;
    step();

    // Time mode: start_time=0, rate=4, time=20, ack after 2 waiting cycles
    ack_delay = 2;
    start_run(1, 0, 4, 20, 1);
    wait_done("time_done", 100);
    chk("time_cnt", longint'(sent_cnt), 3);
    chk("time_done_edge", done_edge - start_edge, 21);
    $display("run time_mode: sent_cnt=%0d done_after=%0d", sent_cnt, done_edge - start_edge);
    stop_run("time_stop");

    // Abort during GAP
    ack_delay = 0;
    start_run(0, 0, 5, 0, 10);
    for (int i = 0; i < 30 && sent_cnt == '0; i++) step();
    chk("gap_abort_reach", longint'(sent_cnt), 1);
    sent_start = 1'b0;
    step();
    chk("gap_abort_busy", longint'(sent_busy), 0);
    chk("gap_abort_done", longint'(sent_done), 0);
    chk("gap_abort_cnt", longint'(sent_cnt), 1);
    $display("run gap_abort: sent_cnt=%0d", sent_cnt);
    step();

    // Abort during SEND: request must stay up until its ack 5 cycles later
    ack_delay = 5;
    start_run(0, 0, 1, 0, 10);
    for (int i = 0; i < 30 && !pkt_req; i++) step();
    chk("send_abort_req", longint'(pkt_req), 1);
    sent_start = 1'b0;
    for (int i = 0; i < 30 && sent_busy; i++) step();
    chk("send_abort_idle", longint'(sent_busy), 0);
    chk("send_abort_cnt", longint'(sent_cnt), 1);
    chk("send_abort_done", longint'(sent_done), 0);
    chk("send_abort_hi", longint'(hi_cycles - hi0), 6);
    $display("run send_abort: sent_cnt=%0d req_high_cycles=%0d", sent_cnt, hi_cycles - hi0);
    step();

    // Zero limits, with ack held high to show no request is ever raised
    ack_hold = 1;
    start_run(0, 5, 1, 1, 0);
    wait_done("zero_num_done", 20);
    chk("zero_num_cnt", longint'(sent_cnt), 0);
    chk("zero_num_nreq", longint'(n_rise - rise0), 0);
    $display("run zero_num: sent_cnt=%0d", sent_cnt);
    stop_run("zero_num_stop");
    start_run(1, 0, 1, 0, 3);
    wait_done("zero_time_done", 20);
    chk("zero_time_cnt", longint'(sent_cnt), 0);
    chk("zero_time_nreq", longint'(n_rise - rise0), 0);
    $display("run zero_time: sent_cnt=%0d", sent_cnt);
    stop_run("zero_time_stop");
    ack_hold = 0;
    step();

    // Config change mid-run is ignored
    ack_delay = 0;
    start_run(0, 2, 1, 0, 2);
    sent_num = 7;
    wait_done("cfg_done", 50);
    chk("cfg_cnt", longint'(sent_cnt), 2);
    $display("run cfg_change: sent_cnt=%0d", sent_cnt);
    stop_run("cfg_stop");

    // Asynchronous reset mid-SEND, then level-high start must not restart
    ack_delay = 3;
    start_run(0, 0, 1, 0, 5);
    for (int i = 0; i < 50 && !(sent_cnt == 64'd1 && pkt_req); i++) step();
    chk("rst_reach", longint'(pkt_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_req", longint'(pkt_req), 0);
    chk("rst_async_busy", longint'(sent_busy), 0);
    chk("rst_async_done", longint'(sent_done), 0);
    chk("rst_async_cnt", longint'(sent_cnt), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("rst_level_no_start", longint'(sent_busy), 0);
    sent_start = 1'b0;
    step();
    ack_delay = 0;
    start_run(0, 1, 1, 0, 1);
    chk("rst_fresh_start", longint'(sent_busy), 1);
    wait_done("rst_fresh_done", 20);
    chk("rst_fresh_cnt", longint'(sent_cnt), 1);
    $display("run reset_restart: sent_cnt=%0d", sent_cnt);
    stop_run("rst_fresh_stop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcm_sent_ctrl.md
# lcm_sent_ctrl

Transmit scheduler for the traffic generator. It takes the software-written send configuration (start, mode, start delay, rate, duration, count) from the register-write block and sequences packet requests to the packet generator over a req/ack handshake. It enforces the start delay and the inter-packet gap, and stops in count mode or time mode. Run status and packet count are exported for register read-back.

## Interface
Parameters:
- CNT_W, 64, width of all counters and config inputs

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- sent_start  in  1  run enable level from register write; run begins on 0→1
- sent_model  in  1  0 = count mode, 1 = time mode
- sent_start_time  in  CNT_W  cycles spent in WAIT before the first request
- sent_rate  in  CNT_W  idle cycles between an ack and the next request
- sent_time  in  CNT_W  run duration in cycles (time mode)
- sent_num  in  CNT_W  packets to send (count mode)
- pkt_ack  in  1  generator accepted the current request
- pkt_req  out  1  request one packet; registered
- sent_busy  out  1  state is WAIT, SEND or GAP
- sent_done  out  1  state is DONE (level)
- sent_cnt  out  CNT_W  packets acked in the current or last run

## Operation
- States: IDLE, WAIT, SEND, GAP, DONE. The FSM holds internal registers start_d, delay_cnt, gap_cnt, run_cnt and latched copies of the config inputs.
- **IDLE:** when start_d==0 and sent_start==1 (rising edge), latch model/start_time/rate/time/num, clear sent_cnt, delay_cnt and run_cnt, then go to WAIT. Config changes during a run are ignored.
- **WAIT:** if (count mode and num==0) or (time mode and time==0), go to DONE with no request. Else if delay_cnt==start_time, go to SEND. Else increment delay_cnt.
- **SEND:** pkt_req=1 and held until pkt_ack. A request is never withdrawn, even after timeout. On pkt_ack, sent_cnt is incremented, then the next state is decided in this order:
  - count mode and sent_cnt+1==num → DONE
  - time mode and run_cnt+1>=time → DONE
  - rate==0 → stay in SEND (back-to-back requests)
  - otherwise → GAP, with gap_cnt loaded with rate
- **GAP:** decrement gap_cnt. In time mode, if run_cnt+1>=time → DONE. Else if gap_cnt==1 → SEND.
- **run_cnt:** increments by 1 every cycle in SEND or GAP and saturates at all-ones.
- **DONE:** sent_done=1 and sent_cnt holds. When sent_start==0 → IDLE.
- **Abort:** sent_start==0 while in WAIT or GAP → IDLE next cycle. In SEND, finish the pending handshake (wait for pkt_ack, count it), then → IDLE. sent_done is not asserted on abort.
- **sent_cnt:** holds its value in IDLE until the next run start.
- **Arithmetic:** all compares are unsigned CNT_W. Counters never wrap except sent_cnt, which wraps modulo 2^CNT_W (unreachable in practice).
- **pkt_ack outside SEND** is ignored.

## Timing
- **Reset values:** state=IDLE, pkt_req=0, sent_busy=0, sent_done=0, sent_cnt=0, and all internal counters 0.
- **Start latency:** if the edge sampling sent_start=1 is edge k, the FSM is in WAIT after k and pkt_req first goes high after edge k+1+start_time.
- **Handshake:** pkt_req is registered from next-state==SEND. A pkt_ack sampled at edge m means pkt_req is low after m when rate>0. pkt_ack may arrive in the first cycle pkt_req is high.
- **Gap:** for rate=R>0, pkt_req is low for exactly R cycles between the ack edge and the next rising edge. For rate=0, pkt_req stays high and one packet is accepted per acked cycle.
- **Status outputs:** sent_busy and sent_done are registered and change on the same edge as the state.
- **rst_n mid-run:** everything returns to reset values immediately. After reset release, a run requires a fresh 0→1 on sent_start; a level already high at release is not a start.

## Test plan
- **Reset:** assert rst_n=0 mid-SEND with pkt_req=1 → all outputs 0 asynchronously; after release, sent_start held at 1 → stays IDLE; sent_start 0→1 → WAIT.
- **Count mode:** model=0, start_time=3, rate=2, num=4, pkt_ack immediate → first pkt_req 4 cycles after the start edge, exactly 4 requests each separated by 2 low cycles, then sent_done=1 and sent_cnt=4.
- **Back-to-back:** model=0, rate=0, num=5, pkt_ack held high → pkt_req high for 5 consecutive cycles, then DONE with sent_cnt=5.
- **Time mode:** model=1, start_time=0, rate=4, time=20, ack delayed 2 cycles per request → DONE reached within 20 cycles of the first SEND, except that a pending request always completes; sent_cnt=3.
- **Abort:** sent_start→0 during GAP → IDLE next cycle, sent_done=0, sent_cnt held. Abort during SEND with ack 5 cycles later → pkt_req stays high until the ack, count+1, then IDLE.
- **Zero limits:** model=0 with num=0, or model=1 with time=0 → WAIT→DONE with no pkt_req ever high and sent_cnt=0. Changing sent_num mid-run has no effect.
